// File: rtl/nios2_vjtag_scan_master_if.sv
// Command/response handshake between a scan initiator and nios2_vjtag_scan_master.
// master: issues scan commands; slave: the scan master engine itself.
interface nios2_vjtag_scan_master_if #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2
) ();
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [DR_WIDTH-1:0] cmd_dr;
    logic                rsp_valid;
    logic [DR_WIDTH-1:0] rsp_dr;

    modport master (
        output cmd_valid, cmd_ir, cmd_dr,
        input  cmd_ready, rsp_valid, rsp_dr
    );

    modport slave (
        input  cmd_valid, cmd_ir, cmd_dr,
        output cmd_ready, rsp_valid, rsp_dr
    );
endinterface

// File: rtl/nios2_vjtag_scan_master.sv
// Virtual-JTAG scan initiator: one IR load plus a full DR scan per command,
// generating vji_tck from clk and returning the bits captured on vji_tdo.
module nios2_vjtag_scan_master #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    nios2_vjtag_scan_master_if.slave bus,
    output logic                    vji_tck,
    output logic                    vji_tdi,
    input  logic                    vji_tdo,
    output logic [IR_WIDTH-1:0]     vji_ir_in,
    output logic                    vji_uir,
    output logic                    vji_cdr,
    output logic                    vji_sdr,
    output logic                    vji_udr,
    output logic                    vji_rti
);

    localparam int CW = (2 * TCK_DIV > 1) ? $clog2(2 * TCK_DIV) : 1;
    localparam int BW = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(2 * TCK_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(TCK_DIV);
    localparam logic [CW-1:0] CNT_RISE = CW'(TCK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DR_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UIR,
        S_CDR,
        S_SDR,
        S_UDR,
        S_RSP
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [DR_WIDTH-1:0] sr_q, sr_d;
    logic [DR_WIDTH-1:0] rsp_dr_q, rsp_dr_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic                ready_q, ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                tck_q, tck_d;
    logic                tdi_q, tdi_d;
    logic                uir_q, uir_d;
    logic                cdr_q, cdr_d;
    logic                sdr_q, sdr_d;
    logic                udr_q, udr_d;
    logic                rti_q, rti_d;
    logic                in_scan_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            sr_q        <= '0;
            rsp_dr_q    <= '0;
            ir_q        <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            tck_q       <= 1'b0;
            tdi_q       <= 1'b0;
            uir_q       <= 1'b0;
            cdr_q       <= 1'b0;
            sdr_q       <= 1'b0;
            udr_q       <= 1'b0;
            rti_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            sr_q        <= sr_d;
            rsp_dr_q    <= rsp_dr_d;
            ir_q        <= ir_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            tck_q       <= tck_d;
            tdi_q       <= tdi_d;
            uir_q       <= uir_d;
            cdr_q       <= cdr_d;
            sdr_q       <= sdr_d;
            udr_q       <= udr_d;
            rti_q       <= rti_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        sr_d     = sr_q;
        ir_d     = ir_q;
        rsp_dr_d = rsp_dr_q;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.cmd_valid && ready_q) begin
                    state_d = S_UIR;
                    ir_d    = bus.cmd_ir;
                    sr_d    = bus.cmd_dr;
                    bit_d   = '0;
                end
            end
            S_UIR, S_CDR, S_UDR: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (state_q == S_UIR) begin
                        state_d = S_CDR;
                    end else if (state_q == S_CDR) begin
                        state_d = S_SDR;
                    end else begin
                        state_d = S_RSP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SDR: begin
                // Capture on the clk edge that drives tck high.
                if (cnt_q == CNT_RISE) begin
                    for (int unsigned i = 0; i < DR_WIDTH - 1; i++) begin
                        sr_d[i] = sr_q[i+1];
                    end
                    sr_d[DR_WIDTH-1] = vji_tdo;
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = S_UDR;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RSP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so every one leaves a flop.
        in_scan_d   = (state_d == S_UIR) || (state_d == S_CDR) ||
                      (state_d == S_SDR) || (state_d == S_UDR);
        tck_d       = in_scan_d && (cnt_d >= CNT_HALF);
        uir_d       = (state_d == S_UIR);
        cdr_d       = (state_d == S_CDR);
        sdr_d       = (state_d == S_SDR);
        udr_d       = (state_d == S_UDR);
        rti_d       = (state_d == S_IDLE);
        ready_d     = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RSP);
        if (state_d == S_RSP) begin
            rsp_dr_d = sr_d;
        end

        if (state_d != S_SDR) begin
            tdi_d = 1'b0;
        end else if (cnt_d == '0) begin
            tdi_d = sr_d[0];
        end else begin
            tdi_d = tdi_q;
        end
    end

    assign bus.cmd_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_dr    = rsp_dr_q;
    assign vji_tck       = tck_q;
    assign vji_tdi       = tdi_q;
    assign vji_ir_in     = ir_q;
    assign vji_uir       = uir_q;
    assign vji_cdr       = cdr_q;
    assign vji_sdr       = sdr_q;
    assign vji_udr       = udr_q;
    assign vji_rti       = rti_q;

endmodule
